// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Wallace multiplier.
package wallace_pkg;

    localparam int MUL_LAT = 3;

    // Baugh-Wooley: in signed mode, invert the cross terms that touch exactly one sign bit.
    function automatic logic bw_pp(input logic a_bit, input logic b_bit, input int i,
                                   input int j, input logic signed_mode, input int n);
        logic p;
        p = a_bit & b_bit;
        if (signed_mode && ((i == n - 1) != (j == n - 1)))
            p = ~p;
        return p;
    endfunction

    function automatic int csa_rows(input int n_rows);
        return 2 * (n_rows / 3) + n_rows % 3;
    endfunction

    function automatic int rows_after(input int n_rows, input int layers);
        int r;
        r = n_rows;
        for (int k = 0; k < layers; k++)
            r = csa_rows(r);
        return r;
    endfunction

    function automatic int layers_to(input int n_rows, input int target);
        int r;
        int k;
        r = n_rows;
        k = 0;
        while (r > target) begin
            r = csa_rows(r);
            k++;
        end
        return k;
    endfunction

endpackage

// File: rtl/csa_row.sv
// One 3:2 carry-save layer: compresses three W-bit vectors into sum and left-shifted carry.
module csa_row #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-2:0] maj;

    for (genvar i = 0; i < W; i++) begin : g_sum
        assign sum[i] = a[i] ^ b[i] ^ c[i];
    end

    // Carry out of the top column is dropped; products are taken modulo 2^W.
    for (genvar i = 0; i < W - 1; i++) begin : g_maj
        assign maj[i] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign carry = {maj, 1'b0};

endmodule

// File: rtl/wallace_mul_pipe.sv
// Three-stage Wallace-tree multiplier, unsigned or Baugh-Wooley signed per operation,
// with a valid/ready handshake on both sides and a tag carried alongside each product.
module wallace_mul_pipe
    import wallace_pkg::*;
#(
    parameter int N  = 8,
    parameter int TW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic            in_signed,
    input  logic [TW-1:0]   in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  out_prod,
    output logic [TW-1:0]   out_tag
);

    localparam int W  = 2 * N;
    localparam int R0 = N + 1;
    localparam int L1 = layers_to(R0, 4);
    localparam int R1 = rows_after(R0, L1);
    localparam int L2 = layers_to(R1, 2);

    logic v1, v2, v3;
    logic ready1, ready2, ready3;

    logic [W-1:0]  s1_rows [R1];
    logic [TW-1:0] s1_tag;
    logic [W-1:0]  s2_sum, s2_cry;
    logic [TW-1:0] s2_tag;

    assign ready3    = !v3 || out_ready;
    assign ready2    = !v2 || ready3;
    assign ready1    = !v1 || ready2;
    assign in_ready  = ready1 && !rst;
    assign out_valid = v3;

    // Partial products; the extra row holds the Baugh-Wooley constants at columns N and 2N-1.
    logic [W-1:0] pp [R0];
    always_comb begin
        for (int i = 0; i < R0; i++)
            pp[i] = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pp[i][i+j] = bw_pp(in_a[j], in_b[i], i, j, in_signed, N);
        if (in_signed) begin
            pp[N][N]   = 1'b1;
            pp[N][W-1] = 1'b1;
        end
    end

    logic [W-1:0] t1 [L1+1][R0];
    for (genvar r = 0; r < R0; r++) begin : g_t1_in
        assign t1[0][r] = pp[r];
    end

    for (genvar k = 0; k < L1; k++) begin : g_s1_lyr
        localparam int C  = rows_after(R0, k);
        localparam int G  = C / 3;
        localparam int CN = csa_rows(C);
        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_row #(.W(W)) u_csa (
                .a     (t1[k][3*g]),
                .b     (t1[k][3*g+1]),
                .c     (t1[k][3*g+2]),
                .sum   (t1[k+1][2*g]),
                .carry (t1[k+1][2*g+1])
            );
        end
        for (genvar r = 0; r < C % 3; r++) begin : g_pass
            assign t1[k+1][2*G+r] = t1[k][3*G+r];
        end
        for (genvar r = CN; r < R0; r++) begin : g_zero
            assign t1[k+1][r] = '0;
        end
    end

    logic [W-1:0] t2 [L2+1][R1];
    for (genvar r = 0; r < R1; r++) begin : g_t2_in
        assign t2[0][r] = s1_rows[r];
    end

    for (genvar k = 0; k < L2; k++) begin : g_s2_lyr
        localparam int C  = rows_after(R1, k);
        localparam int G  = C / 3;
        localparam int CN = csa_rows(C);
        for (genvar g = 0; g < G; g++) begin : g_csa
            csa_row #(.W(W)) u_csa (
                .a     (t2[k][3*g]),
                .b     (t2[k][3*g+1]),
                .c     (t2[k][3*g+2]),
                .sum   (t2[k+1][2*g]),
                .carry (t2[k+1][2*g+1])
            );
        end
        for (genvar r = 0; r < C % 3; r++) begin : g_pass
            assign t2[k+1][2*G+r] = t2[k][3*G+r];
        end
        for (genvar r = CN; r < R1; r++) begin : g_zero
            assign t2[k+1][r] = '0;
        end
    end

    logic [W-1:0] cpa_sum;
    logic [W-1:0] cy;
    assign cy[0] = 1'b0;
    for (genvar i = 0; i < W; i++) begin : g_cpa_sum
        assign cpa_sum[i] = s2_sum[i] ^ s2_cry[i] ^ cy[i];
    end
    for (genvar i = 0; i < W - 1; i++) begin : g_cpa_cy
        assign cy[i+1] = (s2_sum[i] & s2_cry[i]) | (cy[i] & (s2_sum[i] ^ s2_cry[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            out_prod <= '0;
            out_tag  <= '0;
        end else begin
            if (ready1)
                v1 <= in_valid;
            if (ready2)
                v2 <= v1;
            if (ready3) begin
                v3 <= v2;
                // Only real results reach the output registers, so out_prod stays 0 after reset.
                if (v2) begin
                    out_prod <= cpa_sum;
                    out_tag  <= s2_tag;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            for (int r = 0; r < R1; r++)
                s1_rows[r] <= t1[L1][r];
            s1_tag <= in_tag;
        end
        if (ready2 && v1) begin
            s2_sum <= t2[L2][0];
            s2_cry <= t2[L2][1];
            s2_tag <= s1_tag;
        end
    end

endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Bench for wallace_mul_pipe: directed N=8 checks plus an N=16 randomized sweep
// against a plain-arithmetic multiply model.
module tb_wallace_mul_pipe;
    import wallace_pkg::*;

    localparam int NOPS = 10000;
    localparam int MAXC = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_iv, a_ir, a_s, a_ov, a_or;
    logic [7:0]  a_a, a_b;
    logic [3:0]  a_it, a_ot;
    logic [15:0] a_p;

    logic        b_iv, b_ir, b_s, b_ov, b_or;
    logic [15:0] b_a, b_b;
    logic [3:0]  b_it, b_ot;
    logic [31:0] b_p;

    wallace_mul_pipe #(.N(8), .TW(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir), .in_a(a_a), .in_b(a_b),
        .in_signed(a_s), .in_tag(a_it),
        .out_valid(a_ov), .out_ready(a_or), .out_prod(a_p), .out_tag(a_ot)
    );

    wallace_mul_pipe #(.N(16), .TW(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir), .in_a(b_a), .in_b(b_b),
        .in_signed(b_s), .in_tag(b_it),
        .out_valid(b_ov), .out_ready(b_or), .out_prod(b_p), .out_tag(b_ot)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input longint a, input longint b,
                                            input bit s, input int n);
        longint x;
        longint y;
        longint p;
        x = a;
        y = b;
        if (s && x[n-1]) x = x - (longint'(1) << n);
        if (s && y[n-1]) y = y - (longint'(1) << n);
        p = x * y;
        return 64'(p & ((longint'(1) << (2 * n)) - 1));
    endfunction

    int op_a [4];
    int op_b [4];
    int op_t [4];
    bit op_s [4];

    task automatic set_op(input int k, input int a, input int b, input bit s, input int t);
        op_a[k] = a;
        op_b[k] = b;
        op_s[k] = s;
        op_t[k] = t;
    endtask

    task automatic drive8(input int k);
        a_iv = 1'b1;
        a_a  = 8'(op_a[k]);
        a_b  = 8'(op_b[k]);
        a_s  = op_s[k];
        a_it = 4'(op_t[k]);
    endtask

    // Issue n ops on consecutive cycles from an empty pipe with out_ready=1;
    // each result must appear exactly MUL_LAT cycles after its issue cycle.
    task automatic burst8(input int n, input string name);
        for (int cyc = 0; cyc < n + MUL_LAT; cyc++) begin
            @(negedge clk);
            if (cyc >= MUL_LAT) begin
                chk({name, "_valid"}, a_ov, 1);
                chk({name, "_prod"}, a_p,
                    ref_mul(op_a[cyc-MUL_LAT], op_b[cyc-MUL_LAT], op_s[cyc-MUL_LAT], 8));
                chk({name, "_tag"}, a_ot, op_t[cyc-MUL_LAT]);
            end else begin
                chk({name, "_early"}, a_ov, 0);
            end
            if (cyc < n) begin
                chk({name, "_in_ready"}, a_ir, 1);
                drive8(cyc);
            end else begin
                a_iv = 1'b0;
            end
        end
        @(negedge clk);
        chk({name, "_drained"}, a_ov, 0);
    endtask

    initial begin
        int acc;
        int d;
        int sent;
        int recv;
        int cyc;
        bit have;
        logic [63:0] qp [$];
        logic [3:0]  qt [$];

        rst  = 1'b1;
        a_iv = 1'b0; a_a = '0; a_b = '0; a_s = 1'b0; a_it = '0; a_or = 1'b1;
        b_iv = 1'b0; b_a = '0; b_b = '0; b_s = 1'b0; b_it = '0; b_or = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", a_ov, 0);
        chk("rst_prod", a_p, 0);
        chk("rst_tag", a_ot, 0);
        chk("rst_in_ready", a_ir, 0);
        chk("rst_valid16", b_ov, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", a_ir, 1);

        set_op(0, 255, 255, 0, 5);
        burst8(1, "u_max");

        set_op(0, 8'h80, 8'h80, 1, 1);
        set_op(1, 8'hFF, 8'h7F, 1, 2);
        set_op(2, 8'h7F, 8'h80, 1, 3);
        burst8(3, "signed");

        set_op(0, 8'h80, 8'h80, 0, 7);
        set_op(1, 8'h80, 8'h01, 1, 8);
        set_op(2, 8'hFF, 8'h01, 0, 9);
        burst8(3, "mixed");

        // Backpressure: four ops offered against a stalled consumer.
        a_or = 1'b0;
        for (int k = 0; k < 4; k++)
            set_op(k, 20 + 37 * k, 3 + 50 * k, k[0], k + 1);
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                chk("bp_in_ready_low", a_ir, 0);
                chk("bp_hold_valid", a_ov, 1);
                chk("bp_hold_tag", a_ot, 1);
                chk("bp_hold_prod", a_p, ref_mul(op_a[0], op_b[0], op_s[0], 8));
            end
            drive8(acc);
            if (a_ir) acc++;
        end
        chk("bp_accepted", acc, 3);
        d = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_or = 1'b1;
            if (acc < 4) drive8(acc);
            else a_iv = 1'b0;
            #1;
            if (a_iv && a_ir) acc++;
            if (a_ov) begin
                if (d < 4) begin
                    chk("bp_tag", a_ot, op_t[d]);
                    chk("bp_prod", a_p, ref_mul(op_a[d], op_b[d], op_s[d], 8));
                end else begin
                    chk("bp_extra", a_ov, 0);
                end
                d++;
            end
        end
        chk("bp_delivered", d, 4);

        // Reset with two ops in flight.
        set_op(0, 8'h12, 8'h34, 0, 10);
        set_op(1, 8'hF0, 8'h0F, 1, 11);
        @(negedge clk); drive8(0);
        @(negedge clk); drive8(1);
        @(negedge clk); a_iv = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", a_ov, 0);
        chk("mid_rst_prod", a_p, 0);
        chk("mid_rst_tag", a_ot, 0);
        chk("mid_rst_in_ready", a_ir, 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_rst_no_stale", a_ov, 0);
        end
        set_op(0, 8'h9C, 8'hC3, 1, 12);
        burst8(1, "post_rst");

        // Randomized N=16 sweep with toggling in_valid and out_ready.
        sent = 0;
        recv = 0;
        cyc  = 0;
        have = 1'b0;
        while ((sent < NOPS || recv < NOPS) && cyc < MAXC) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < NOPS && $urandom_range(3) != 0) begin
                have = 1'b1;
                b_a  = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
                b_b  = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
                b_s  = 1'($urandom_range(1));
                b_it = 4'(sent);
            end
            b_iv = have;
            b_or = ($urandom_range(3) != 0);
            #1;
            if (b_ov && b_or) begin
                if (qt.size() == 0) begin
                    chk("rnd_unexpected", b_ov, 0);
                end else begin
                    chk("rnd_prod", b_p, qp.pop_front());
                    chk("rnd_tag", b_ot, qt.pop_front());
                end
                recv++;
            end
            if (b_iv && b_ir) begin
                qp.push_back(ref_mul(b_a, b_b, b_s, 16));
                qt.push_back(b_it);
                sent++;
                have = 1'b0;
            end
        end
        b_iv = 1'b0;
        chk("rnd_sent", sent, NOPS);
        chk("rnd_recv", recv, NOPS);
        chk("rnd_queue_empty", qt.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
